// File: rtl/data_sram_resp.sv
// Data-SRAM port responder: word RAM plus an MMIO window (LED, NUM, SWITCH, TIMER, CMP).
// Every read returns one cycle after its request; a sticky timer-compare interrupt is raised.
module data_sram_resp #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num,
  output logic        timer_int
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;
  localparam logic [15:0] MMIO_BASE  = 16'hBFAF;
  localparam logic [15:0] OFF_LED    = 16'hF000;
  localparam logic [15:0] OFF_NUM    = 16'hF010;
  localparam logic [15:0] OFF_SWITCH = 16'hF020;
  localparam logic [15:0] OFF_TIMER  = 16'hE000;
  localparam logic [15:0] OFF_CMP    = 16'hE004;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic              is_mmio;
  logic [15:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_req;
  logic              wr_req;
  logic              sel_led;
  logic              sel_num;
  logic              sel_switch;
  logic              sel_timer;
  logic              sel_cmp;
  logic              wr_led;
  logic              wr_num;
  logic              wr_timer;
  logic              wr_cmp;
  logic              ram_we;
  logic              ram_re;
  logic              addr_lsb_unused;

  assign is_mmio  = data_sram_addr[31:16] == MMIO_BASE;
  assign mmio_off = {data_sram_addr[15:2], 2'b00};
  assign ram_idx  = data_sram_addr[RAM_AW+1:2];
  assign rd_req   = data_sram_en && (data_sram_wen == 4'b0000);
  assign wr_req   = data_sram_en && (data_sram_wen != 4'b0000);
  assign addr_lsb_unused = ^data_sram_addr[1:0];

  assign sel_led    = is_mmio && (mmio_off == OFF_LED);
  assign sel_num    = is_mmio && (mmio_off == OFF_NUM);
  assign sel_switch = is_mmio && (mmio_off == OFF_SWITCH);
  assign sel_timer  = is_mmio && (mmio_off == OFF_TIMER);
  assign sel_cmp    = is_mmio && (mmio_off == OFF_CMP);

  assign wr_led   = wr_req && sel_led;
  assign wr_num   = wr_req && sel_num;
  assign wr_timer = wr_req && sel_timer;
  assign wr_cmp   = wr_req && sel_cmp;
  // RAM has no reset, so block its write strobe while reset is held to abort in-flight stores.
  assign ram_we   = rst && wr_req && !is_mmio;
  assign ram_re   = rd_req && !is_mmio;

  logic [7:0]  sw_meta;
  logic [7:0]  sw_sync;
  logic [31:0] timer;
  logic [31:0] cmp;
  logic        hit;
  logic [31:0] mmio_rd;
  logic [31:0] mmio_q;
  logic [31:0] ram_q;
  logic        rd_from_ram;
  logic [15:0] led_wr;
  logic [31:0] mem [RAM_DEPTH];

  assign led_wr = {data_sram_wen[1] ? data_sram_wdata[15:8] : led[15:8],
                   data_sram_wen[0] ? data_sram_wdata[7:0]  : led[7:0]};

  always_comb begin
    mmio_rd = 32'h0;
    if (sel_led)         mmio_rd = {16'h0, led};
    else if (sel_num)    mmio_rd = num;
    else if (sel_switch) mmio_rd = {24'h0, sw_sync};
    else if (sel_timer)  mmio_rd = timer;
    else if (sel_cmp)    mmio_rd = cmp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_meta     <= 8'h0;
      sw_sync     <= 8'h0;
      timer       <= TIMER_RST;
      cmp         <= 32'hFFFF_FFFF;
      hit         <= 1'b0;
      timer_int   <= 1'b0;
      led         <= 16'h0;
      num         <= 32'h0;
      mmio_q      <= 32'h0;
      rd_from_ram <= 1'b0;
    end else begin
      sw_meta <= switch;
      sw_sync <= sw_meta;
      // A timer write replaces the increment; unwritten bytes keep the pre-increment value.
      timer   <= wr_timer ? byte_merge(timer, data_sram_wdata, data_sram_wen) : timer + 32'd1;
      if (wr_cmp) cmp <= byte_merge(cmp, data_sram_wdata, data_sram_wen);
      hit <= (timer == cmp);
      if (wr_cmp)   timer_int <= 1'b0;
      else if (hit) timer_int <= 1'b1;
      if (wr_led) led <= led_wr;
      if (wr_num) num <= byte_merge(num, data_sram_wdata, data_sram_wen);
      if (rd_req) begin
        rd_from_ram <= !is_mmio;
        if (is_mmio) mmio_q <= mmio_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
    if (ram_re) ram_q <= mem[ram_idx];
  end

  assign data_sram_rdata = rd_from_ram ? ram_q : mmio_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model of the port.
module tb_data_sram_resp;
  localparam int RAM_AW = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  sw = 8'h0;
  logic [15:0] led;
  logic [31:0] num;
  logic        tint;

  data_sram_resp #(.RAM_AW(RAM_AW), .TIMER_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata), .switch(sw), .led(led), .num(num), .timer_int(tint)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ram [int];
  logic [31:0] m_timer, m_cmp, m_rdata, m_num;
  logic [15:0] m_led;
  logic        m_hit, m_int;
  logic [7:0]  sw_hist [2];  // [0] sampled at last edge, [1] the edge before

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int idx;
    idx = int'(a[RAM_AW+1:2]);
    if (a[31:16] != 16'hBFAF) return m_ram.exists(idx) ? m_ram[idx] : 32'h0;
    case ({a[15:2], 2'b00})
      16'hF000: return {16'h0, m_led};
      16'hF010: return m_num;
      16'hF020: return {24'h0, sw_hist[1]};
      16'hE000: return m_timer;
      16'hE004: return m_cmp;
      default:  return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_timer = 32'h0; m_cmp = 32'hFFFF_FFFF; m_rdata = 32'h0; m_led = 16'h0; m_num = 32'h0;
      m_hit = 1'b0; m_int = 1'b0; sw_hist[0] = 8'h0; sw_hist[1] = 8'h0;
    end else begin
      logic [31:0] t_pre, c_pre, lw;
      logic        h_pre;
      t_pre = m_timer; c_pre = m_cmp; h_pre = m_hit;
      if (en && wen == 4'h0) m_rdata = m_read(addr);
      m_timer = t_pre + 32'd1;
      m_hit   = (t_pre == c_pre);
      m_int   = m_int | h_pre;
      if (en && wen != 4'h0) begin
        if (addr[31:16] != 16'hBFAF) begin
          m_ram[int'(addr[RAM_AW+1:2])] = merge(m_read(addr), wdata, wen);
        end else begin
          case ({addr[15:2], 2'b00})
            16'hF000: begin lw = merge({16'h0, m_led}, wdata, wen); m_led = lw[15:0]; end
            16'hF010: m_num = merge(m_num, wdata, wen);
            16'hE000: m_timer = merge(t_pre, wdata, wen);
            16'hE004: begin m_cmp = merge(c_pre, wdata, wen); m_int = 1'b0; end
            default: ;
          endcase
        end
      end
      sw_hist[1] = sw_hist[0];
      sw_hist[0] = sw;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      check("model_rdata", rdata, m_rdata);
      check("model_led", {16'h0, led}, {16'h0, m_led});
      check("model_num", num, m_num);
      check("model_timer_int", {31'h0, tint}, {31'h0, m_int});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  localparam logic [31:0] A_LED = 32'hBFAF_F000;
  localparam logic [31:0] A_NUM = 32'hBFAF_F010;
  localparam logic [31:0] A_SW  = 32'hBFAF_F020;
  localparam logic [31:0] A_TMR = 32'hBFAF_E000;
  localparam logic [31:0] A_CMP = 32'hBFAF_E004;

  function automatic logic [31:0] ram_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    if (a[31:16] == 16'hBFAF) a[31:16] = 16'h0000;
    a[RAM_AW+1:2] = idx[RAM_AW-1:0];
    return a;
  endfunction

  initial begin
    logic [31:0] t, a, d;
    logic [3:0]  w;
    logic [15:0] off;
    int          k;

    #7;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num, 32'h0);
    check("reset_timer_int", {31'h0, tint}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // RAM write then read
    drive(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF);
    check("raw_hold_on_write", rdata, 32'h0);
    drive(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("raw_read", rdata, 32'hDEAD_BEEF);

    // byte merge, with and without low address bits, and aliasing
    drive(1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344);
    drive(1'b1, 4'h2, 32'h0000_0020, 32'hAABB_CCDD);
    drive(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("byte_merge", rdata, 32'h1122_CC44);
    drive(1'b1, 4'hF, 32'h0000_0027, 32'h1122_3344);
    drive(1'b1, 4'h2, 32'h0000_0027, 32'hAABB_CCDD);
    drive(1'b1, 4'h0, 32'h0000_0027, 32'h0);
    check("byte_merge_lsb11", rdata, 32'h1122_CC44);
    drive(1'b1, 4'h0, 32'h1234_4024, 32'h0);
    check("ram_alias", rdata, 32'h1122_CC44);

    // LED register and rdata hold
    drive(1'b1, 4'hF, A_LED, 32'hFFFF_1234);
    check("led_out", {16'h0, led}, 32'h0000_1234);
    drive(1'b1, 4'h0, A_LED, 32'h0);
    check("led_read", rdata, 32'h0000_1234);
    idle(3);
    check("rdata_hold_idle", rdata, 32'h0000_1234);
    drive(1'b1, 4'h5, A_NUM, 32'hCAFE_F00D);
    check("num_out", num, 32'h00FE_000D);
    check("rdata_hold_write", rdata, 32'h0000_1234);

    // timer write and wrap
    drive(1'b1, 4'hF, A_TMR, 32'hFFFF_FFFE);
    idle(1);
    drive(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_ffffffff", rdata, 32'hFFFF_FFFF);
    drive(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_wrap", rdata, 32'h0000_0000);

    // compare interrupt: set timing
    t = m_timer;
    drive(1'b1, 4'hF, A_CMP, t + 32'd5);
    check("int_cleared_by_cmp", {31'h0, tint}, 32'h0);
    idle(5);
    check("int_not_yet", {31'h0, tint}, 32'h0);
    idle(1);
    check("int_set", {31'h0, tint}, 32'h1);

    // CMP write on the set cycle: clear wins
    t = m_timer;
    drive(1'b1, 4'hF, A_CMP, t + 32'd5);
    idle(5);
    drive(1'b1, 4'hF, A_CMP, t + 32'd1000);
    check("int_clear_wins", {31'h0, tint}, 32'h0);
    idle(2);
    check("int_stays_clear", {31'h0, tint}, 32'h0);

    // sticky, then cleared by a later CMP write
    t = m_timer;
    drive(1'b1, 4'hF, A_CMP, t + 32'd5);
    idle(9);
    check("int_sticky", {31'h0, tint}, 32'h1);
    drive(1'b1, 4'hF, A_CMP, t + 32'd100000);
    check("int_late_clear", {31'h0, tint}, 32'h0);

    // switch synchroniser latency
    sw = 8'hA5;
    drive(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_old", rdata, 32'h0);
    idle(2);
    drive(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_new", rdata, 32'h0000_00A5);
    sw = 8'h3C;
    drive(1'b1, 4'h0, A_SW, 32'h0);
    drive(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_one_cycle", rdata, 32'h0000_00A5);
    drive(1'b1, 4'h0, A_SW, 32'h0);
    check("switch_two_cycles", rdata, 32'h0000_003C);

    // asynchronous reset mid-stream
    drive(1'b1, 4'hF, A_NUM, 32'h1234_5678);
    drive(1'b1, 4'h0, A_NUM, 32'h0);
    check("pre_reset_rdata", rdata, 32'h1234_5678);
    en = 1'b1; wen = 4'hF; addr = A_LED; wdata = 32'h0000_BEEF;
    #2 rst = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_led", {16'h0, led}, 32'h0);
    check("async_rst_num", num, 32'h0);
    check("async_rst_int", {31'h0, tint}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 4'h0, A_TMR, 32'h0);
    check("timer_after_reset", rdata, 32'h0);
    check("led_write_aborted", {16'h0, led}, 32'h0);
    drive(1'b1, 4'h0, A_CMP, 32'h0);
    check("cmp_after_reset", rdata, 32'hFFFF_FFFF);

    // random traffic against the model
    for (int i = 16; i < 24; i++) drive(1'b1, 4'hF, ram_addr(i), $urandom);
    for (int i = 0; i < 2500; i++) begin
      k = int'($urandom_range(0, 15));
      d = $urandom;
      w = 4'($urandom_range(1, 15));
      off = 16'h1234;
      if ($urandom_range(0, 31) == 0) sw = 8'($urandom);
      case (k)
        0, 1, 2: drive(1'b1, w, ram_addr(16 + int'($urandom_range(0, 7))), d);
        3, 4, 5: drive(1'b1, 4'h0, ram_addr(16 + int'($urandom_range(0, 7))), 32'h0);
        6:  drive(1'b1, w, A_LED | 32'($urandom_range(0, 3)), d);
        7:  drive(1'b1, 4'h0, ($urandom_range(0, 1) == 0 ? A_LED : A_NUM), 32'h0);
        8:  drive(1'b1, w, A_NUM | 32'($urandom_range(0, 3)), d);
        9:  drive(1'b1, 4'h0, A_TMR, 32'h0);
        10: if ($urandom_range(0, 3) == 0) drive(1'b1, w, A_TMR, d);
            else drive(1'b1, 4'h0, A_TMR | 32'h3, 32'h0);
        11: drive(1'b1, 4'hF, A_CMP, m_timer + 32'($urandom_range(1, 8)));
        12: drive(1'b1, ($urandom_range(0, 1) == 0 ? 4'h0 : w), A_CMP, d);
        13: drive(1'b1, ($urandom_range(0, 1) == 0 ? 4'h0 : w), A_SW, d);
        14: begin
          case ($urandom_range(0, 3))
            0: off = 16'h0000;
            1: off = 16'hF004;
            2: off = 16'hE008;
            default: off = 16'hF030;
          endcase
          a = {16'hBFAF, off};
          drive(1'b1, ($urandom_range(0, 1) == 0 ? 4'h0 : w), a, d);
        end
        default: idle(1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: run did not complete, time %0t limit %0d", $time, 1000000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
